// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared state encoding and constants for the slow-control frame shifter
package sc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RST   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } sc_state_e;

  localparam int MAROC_FRAME_W = 829;
  localparam int MISMATCH_W    = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [MISMATCH_W-1:0] sat_inc(input logic [MISMATCH_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sc_clk_div.sv
// rtl/sc_clk_div.sv - serial clock generator: CLK_DIV cycles low then CLK_DIV cycles high per bit
module sc_clk_div
  import sc_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic en_i,
  output logic ck_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);

  localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PH_W-1:0] phase_q, phase_d;
  logic            ck_q, ck_d;
  logic            last_ph;

  assign last_ph = en_i && (phase_q == PH_W'(CLK_DIV - 1));

  always_comb begin
    phase_d = phase_q;
    ck_d    = ck_q;
    if (!en_i) begin
      phase_d = '0;
      ck_d    = 1'b0;
    end else if (last_ph) begin
      phase_d = '0;
      ck_d    = ~ck_q;
    end else begin
      phase_d = phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      phase_q <= '0;
      ck_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      ck_q    <= ck_d;
    end
  end

  // rise_stb marks the last low cycle (ASIC samples next), fall_stb the last high cycle (bit ends).
  assign ck_o       = ck_q;
  assign rise_stb_o = last_ph & ~ck_q;
  assign fall_stb_o = last_ph & ck_q;

endmodule

// File: rtl/sc_frame_shifter.sv
// rtl/sc_frame_shifter.sv - slow-control frame serialiser with optional readback (SC_READBACK_EN)
module sc_frame_shifter
  import sc_pkg::*;
#(
  parameter int FRAME_W    = MAROC_FRAME_W,
  parameter int CLK_DIV    = 1,
  parameter int RST_CYCLES = 2,
  parameter int LSB_FIRST  = 1
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic [FRAME_W-1:0]    frame_in,
  input  logic                  q_sc_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  verify_ok_out,
  output logic [MISMATCH_W-1:0] mismatch_cnt_out,
  output logic                  d_sc_out,
  output logic                  ck_sc_out,
  output logic                  rstn_sc_out,
  output logic [1:0]            state_out
);

`ifdef SC_READBACK_EN
  localparam int NBITS = 2 * FRAME_W;
`else
  localparam int NBITS = FRAME_W;
`endif
  localparam int BC_W = $clog2(2 * FRAME_W + 1);
  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  sc_state_e        state_q;
  logic [FRAME_W-1:0] frame_q;
  logic [FRAME_W-1:0] frame_load;
  logic [BC_W-1:0]  bit_cnt_q;
  logic [RC_W-1:0]  rst_cnt_q;
  logic             busy_q, done_q, d_q, rstn_q;
  logic             accept, shift_en, last_bit, frame_end;
  logic             rise_stb, fall_stb;

  // Frame is stored in shift order so bit 0 always goes out next.
  always_comb begin
    frame_load = frame_in;
    if (LSB_FIRST == 0) begin
      for (int i = 0; i < FRAME_W; i++) frame_load[i] = frame_in[FRAME_W-1-i];
    end
  end

  assign accept    = start_in && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign shift_en  = (state_q == ST_SHIFT);
  assign last_bit  = (bit_cnt_q == BC_W'(NBITS - 1));
  assign frame_end = shift_en && fall_stb && last_bit;

  sc_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk_in     (clk_in),
    .reset_in   (reset_in),
    .en_i       (shift_en),
    .ck_o       (ck_sc_out),
    .rise_stb_o (rise_stb),
    .fall_stb_o (fall_stb)
  );

  // Frame register rotates, so a second pass naturally resends the same bits.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      rst_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      d_q       <= 1'b0;
      rstn_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state_q   <= ST_RST;
            frame_q   <= frame_load;
            bit_cnt_q <= '0;
            rst_cnt_q <= '0;
            busy_q    <= 1'b1;
            rstn_q    <= 1'b0;
            d_q       <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RST: begin
          if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
            state_q <= ST_SHIFT;
            rstn_q  <= 1'b1;
            d_q     <= frame_q[0];
            frame_q <= {frame_q[0], frame_q[FRAME_W-1:1]};
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (fall_stb) begin
            if (last_bit) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              d_q       <= frame_q[0];
              frame_q   <= {frame_q[0], frame_q[FRAME_W-1:1]};
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef SC_READBACK_EN
  logic [MISMATCH_W-1:0] mm_q;
  logic                  vok_q;
  logic                  sample_pt;

  // In pass 2 the bit on d_sc equals the frame bit the chip should be returning.
  assign sample_pt = shift_en && rise_stb && (bit_cnt_q >= BC_W'(FRAME_W));

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      mm_q  <= '0;
      vok_q <= 1'b1;
    end else if (accept) begin
      mm_q  <= '0;
      vok_q <= 1'b1;
    end else begin
      if (sample_pt && (q_sc_in != d_q)) mm_q <= sat_inc(mm_q);
      if (frame_end) vok_q <= (mm_q == '0);
    end
  end

  assign mismatch_cnt_out = mm_q;
  assign verify_ok_out    = vok_q;
`else
  logic unused_q_sc;
  assign unused_q_sc      = q_sc_in;
  assign mismatch_cnt_out = '0;
  assign verify_ok_out    = 1'b1;
`endif

  assign busy_out    = busy_q;
  assign done_out    = done_q;
  assign d_sc_out    = d_q;
  assign rstn_sc_out = rstn_q;
  assign state_out   = state_q;

endmodule
